// File: rtl/flash_reader.sv
// flash_reader: boots a P30 NOR flash into read-array mode, then serves
// 32-bit word reads as two back-to-back asynchronous halfword reads.
module flash_reader #(
  parameter int READ_CYCLES = 6,
  parameter int WE_CYCLES   = 4,
  parameter int RST_CYCLES  = 8,
  parameter int WAKE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [22:0] addr,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic [22:0] flash_a,
  inout  wire  [15:0] flash_d,
  output logic        flash_rp_n,
  output logic        flash_vpen,
  output logic        flash_ce_n,
  output logic        flash_oe_n,
  output logic        flash_we_n
);

  localparam int CW = 8;

  typedef enum logic [2:0] {
    RST_HOLD, WAKE, CMD, CMD_REC,
    READY, RD_LO, RD_HI, ACK
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt;
  logic            w_done;
  logic [20:0]     r_addr;
  logic [31:0]     r_rdata;
  logic            w_drive;
  logic            w_rd;
  logic            w_unused;

  // Counter preload for the state being entered.
  function automatic logic [CW-1:0] reload(input state_t s);
    case (s)
      RST_HOLD: reload = CW'(RST_CYCLES - 1);
      WAKE:     reload = CW'(WAKE_CYCLES - 1);
      CMD:      reload = CW'(WE_CYCLES - 1);
      RD_LO:    reload = CW'(READ_CYCLES - 1);
      RD_HI:    reload = CW'(READ_CYCLES - 1);
      default:  reload = '0;
    endcase
  endfunction

  always_comb begin
    w_done = (r_cnt == '0);
    w_next = r_state;
    unique case (r_state)
      RST_HOLD: if (w_done) w_next = WAKE;
      WAKE:     if (w_done) w_next = CMD;
      CMD:      if (w_done) w_next = CMD_REC;
      CMD_REC:  w_next = READY;
      READY:    if (req) w_next = RD_LO;
      RD_LO:    if (w_done) w_next = RD_HI;
      RD_HI:    if (w_done) w_next = ACK;
      ACK:      w_next = READY;
      default:  w_next = RST_HOLD;
    endcase
    if (w_next != r_state) begin
      w_cnt = reload(w_next);
    end else if (!w_done) begin
      w_cnt = r_cnt - 1'b1;
    end else begin
      w_cnt = r_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RST_HOLD;
      r_cnt   <= CW'(RST_CYCLES - 1);
      r_addr  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (r_state == READY && req) begin
        r_addr <= addr[22:2];
      end
      if (r_state == RD_LO && w_done) begin
        r_rdata[15:0] <= flash_d;
      end
      if (r_state == RD_HI && w_done) begin
        r_rdata[31:16] <= flash_d;
      end
    end
  end

  assign w_rd     = (r_state == RD_LO) || (r_state == RD_HI);
  assign w_drive  = (r_state == CMD) || (r_state == CMD_REC);
  assign w_unused = ^addr[1:0];

  assign flash_a = (r_state == RD_LO) ? {r_addr, 2'b00} :
                   (r_state == RD_HI) ? {r_addr, 2'b10} :
                   23'd0;
  assign flash_d    = w_drive ? 16'h00FF : 16'hzzzz;
  assign flash_rp_n = (r_state != RST_HOLD);
  assign flash_vpen = 1'b0;
  assign flash_ce_n = !(w_rd || r_state == CMD);
  assign flash_oe_n = !w_rd;
  assign flash_we_n = (r_state != CMD);
  assign rdata      = r_rdata;
  assign ack        = (r_state == ACK);
  assign busy       = (r_state != READY);

endmodule

// File: doc/flash_reader.md
# flash_reader

Read-only controller for the board's 16-bit parallel NOR flash (P30-family, asynchronous read mode). After reset it runs the power-up sequence: hold reset, wait for recovery, then write the Read-Array command. It then serves 32-bit word reads from the CPU bus side by performing two back-to-back halfword reads, low half first. It sits between the CPU's peripheral bus and the top-level flash pins, replacing direct pin wiring to the flash model.

## Interface

Parameters:
- READ_CYCLES, 6, clocks per halfword access (address-to-sample); minimum 2
- WE_CYCLES, 4, clocks flash_we_n is held low for the command write
- RST_CYCLES, 8, clocks flash_rp_n stays low after rst_n deasserts
- WAKE_CYCLES, 8, clocks between flash_rp_n rising and the command write

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- req  in  1  read request, level; held high until ack
- addr  in  23  byte address; bits [1:0] ignored (word aligned)
- rdata  out  32  read word; {high halfword, low halfword}
- ack  out  1  one-cycle pulse, rdata valid in the same cycle
- busy  out  1  high whenever the state is not READY
- flash_a  out  23  flash byte address; bit 0 always 0
- flash_d  inout  16  flash data; driven only during the command write, otherwise Z
- flash_rp_n  out  1  flash reset, active low
- flash_vpen  out  1  write protect, constant 0
- flash_ce_n, flash_oe_n, flash_we_n  out  1 each  flash strobes, active low

## Operation

States: RST_HOLD, WAKE, CMD, CMD_REC, READY, RD_LO, RD_HI, ACK. One down-counter is shared by all timed states and reloads on every state entry.

- **RST_HOLD:** flash_rp_n=0. Lasts RST_CYCLES clocks, then moves to WAKE.
- **WAKE:** flash_rp_n=1, all strobes high. Lasts WAKE_CYCLES clocks, then moves to CMD.
- **CMD:**
  - flash_a=0, flash_d=16'h00FF driven.
  - flash_ce_n=0 and flash_we_n=0 for WE_CYCLES clocks.
- **CMD_REC:** one clock with flash_we_n=1, flash_ce_n=1, flash_d still driven (data hold). Then moves to READY with flash_d released to Z.
- **READY:**
  - busy=0.
  - If req=1, latch addr[22:2] and move to RD_LO. busy rises the next cycle.
- **RD_LO:**
  - flash_a={addr[22:2],2'b00}, flash_ce_n=0, flash_oe_n=0.
  - On the READ_CYCLES-th clock, capture flash_d into rdata[15:0], then move to RD_HI.
- **RD_HI:**
  - flash_a={addr[22:2],2'b10}; ce_n and oe_n stay low with no deassertion gap.
  - On the READ_CYCLES-th clock, capture flash_d into rdata[31:16], then move to ACK.
- **ACK:**
  - ce_n=1, oe_n=1, ack=1 for exactly one clock.
  - Then return to READY. A new req is accepted no earlier than the cycle after ACK.

Other rules:
- req seen while busy (boot or transfer) is not lost. It is accepted on the first READY cycle if it is still high.
- rdata updates only in RD_LO/RD_HI. It holds the last word until the next read; the low half changes mid-transfer, so consumers use rdata only at ack.
- flash_we_n=1 in every state except CMD; writes and erases are never issued.
- **Asynchronous reset (including mid-read or mid-command):**
  - state=RST_HOLD, flash_rp_n=0, flash_ce_n/oe_n/we_n=1, flash_d=Z.
  - flash_a=0, rdata=0, ack=0, busy=1.
  - A pending transfer is abandoned with no ack.

## Timing

- Reset values are as listed under Operation.
- **Boot length:** READY is reached RST_CYCLES+WAKE_CYCLES+WE_CYCLES+1 clocks after the first rising edge with rst_n=1. With defaults that is 21 clocks.
- **Read latency:** req sampled in READY at edge 0, ack high in the cycle after edge 2·READ_CYCLES. With defaults, ack is at cycle 13 and throughput is one word per 14 clocks.
- **Address validity:** flash_a is stable for READ_CYCLES clocks before each sample, i.e. 120 ns at defaults (≥ tAVQV). The flash sees one continuous CE/OE window per word.

## Test plan

- **Boot:** release rst_n and monitor the pins. Required: rp_n low 8 clocks, high 8 clocks, then we_n and ce_n low 4 clocks with flash_d=16'h00FF. Then one hold clock, then busy falls at clock 21.
- **Single read:** flash halfwords 0x80=16'h1234 and 0x81=16'h5678; req with addr=23'h000100. Required: flash_a=0x100 then 0x102, rdata=32'h56781234 with ack at cycle 13, one-cycle ack.
- **Held request during boot:** req high from reset release with addr=0. Required: no flash read before clock 21, and exactly one ack returning halfwords 0 and 1.
- **Back-to-back reads:** req held high across addr 0x7FFFFC then 0x000004. Required: two acks 14 clocks apart, correct data, and top address reaching flash_a=0x7FFFFE without wrap.
- **Reset mid-read:** pulse rst_n low during RD_HI. Required: immediate reset values, no ack, and the full boot sequence repeats. A subsequent read returns correct data.
- **Misaligned address:** addr=23'h000103. Required: identical accesses and data as for 0x000100.
